// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch-address generator: state encodings,
// chip-enable levels, address type and the next-pc selector result record.
package pc_fetch_ctrl_pkg;

    typedef logic [31:0] inst_addr_t;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_RUN  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam inst_addr_t ZERO_WORD      = 32'h0000_0000;
    localparam inst_addr_t FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        inst_addr_t next_pc;
        logic       load_en;
        logic [1:0] next_state;
        inst_addr_t next_pend;
    } fetch_sel_t;

    function automatic logic is_misaligned(input inst_addr_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc priority mux for pc_fetch_ctrl: picks the next fetch
// address, the next FSM state and the pending-redirect buffer contents.
module pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter inst_addr_t  RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic [1:0] state_i,
    input  inst_addr_t pc_i,
    input  inst_addr_t pend_addr_i,
    input  logic       flush_i,
    input  inst_addr_t new_pc_i,
    input  logic       stall_i,
    input  logic       branch_i,
    input  inst_addr_t branch_target_i,
    output fetch_sel_t sel_o
);

    // NOTE: every field gets a default first so no path through the case leaves
    // a field unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_o.next_pc    = pc_i;
        sel_o.load_en    = 1'b0;
        sel_o.next_state = state_i;
        sel_o.next_pend  = pend_addr_i;

        case (state_i)
            FETCH_IDLE: begin
                sel_o.next_pc    = RESET_PC;
                sel_o.load_en    = 1'b1;
                sel_o.next_state = FETCH_RUN;
            end

            FETCH_RUN: begin
                if (flush_i) begin
                    sel_o.next_pc   = new_pc_i;
                    sel_o.load_en   = 1'b1;
                    sel_o.next_pend = ZERO_WORD;
                end else if (stall_i && branch_i) begin
                    sel_o.next_pend  = branch_target_i;
                    sel_o.next_state = FETCH_HOLD;
                end else if (stall_i) begin
                    sel_o.load_en = 1'b0;
                end else if (branch_i) begin
                    sel_o.next_pc = branch_target_i;
                    sel_o.load_en = 1'b1;
                end else begin
                    // Modulo-2^32 increment: the top word wraps to zero silently.
                    sel_o.next_pc = pc_i + inst_addr_t'(PC_STEP);
                    sel_o.load_en = 1'b1;
                end
            end

            FETCH_HOLD: begin
                if (flush_i) begin
                    sel_o.next_pc    = new_pc_i;
                    sel_o.load_en    = 1'b1;
                    sel_o.next_pend  = ZERO_WORD;
                    sel_o.next_state = FETCH_RUN;
                end else if (stall_i) begin
                    // Newest branch wins while the stall persists.
                    if (branch_i) begin
                        sel_o.next_pend = branch_target_i;
                    end
                end else begin
                    sel_o.next_pc    = branch_i ? branch_target_i : pend_addr_i;
                    sel_o.load_en    = 1'b1;
                    sel_o.next_pend  = ZERO_WORD;
                    sel_o.next_state = FETCH_RUN;
                end
            end

            default: begin
                sel_o.next_pend  = ZERO_WORD;
                sel_o.next_state = FETCH_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch-address generator with a one-entry pending-redirect buffer.
// Optional build macro FETCH_ALIGN_CHECK_EN adds fetch_misalign_o and gates ce on misaligned fetches.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter inst_addr_t  RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic [31:0] pc,
    output logic        ce,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        fetch_misalign_o,
`endif
    output logic        redirect_pend_o
);

    logic [1:0] state_q, state_d;
    inst_addr_t pc_q, pc_d;
    inst_addr_t pend_addr_q, pend_addr_d;
    logic       ce_q, ce_d;
    fetch_sel_t sel;

    // Only the IF bit of the stall vector matters at this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    pc_next_sel #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_next_sel (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .pend_addr_i     (pend_addr_q),
        .flush_i         (flush),
        .new_pc_i        (new_pc),
        .stall_i         (stall[0]),
        .branch_i        (branch_flag_i),
        .branch_target_i (branch_target_address_i),
        .sel_o           (sel)
    );

    assign state_d     = sel.next_state;
    assign pend_addr_d = sel.next_pend;
    assign pc_d        = sel.load_en ? sel.next_pc : pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = sel.load_en ? is_misaligned(sel.next_pc) : misalign_q;
    assign ce_d       = sel.load_en ? (misalign_d ? CHIP_DISABLE : CHIP_ENABLE) : ce_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign_o = misalign_q;
`else
    // Once the first load leaves S_IDLE, ce latches high until the next reset.
    assign ce_d = sel.load_en ? CHIP_ENABLE : ce_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            pend_addr_q <= ZERO_WORD;
            ce_q        <= CHIP_DISABLE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            ce_q        <= ce_d;
        end
    end

    assign pc              = pc_q;
    assign ce              = ce_q;
    assign redirect_pend_o = (state_q == FETCH_HOLD);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a vector table plus hand-written
// corner sequences, expected results queued at drive time and popped after the edge.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pend_o;
    logic        mis;

    pc_fetch_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .pc                      (pc),
        .ce                      (ce),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetch_misalign_o        (mis),
`endif
        .redirect_pend_o         (redirect_pend_o)
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign mis = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall0;
        logic        flush;
        logic [31:0] new_pc;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_ce;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check({e.tag, ".pc"},   pc, e.pc);
        check({e.tag, ".ce"},   {31'd0, ce}, {31'd0, e.ce});
        check({e.tag, ".pend"}, {31'd0, redirect_pend_o}, {31'd0, e.pend});
`ifdef FETCH_ALIGN_CHECK_EN
        check({e.tag, ".mis"},  {31'd0, mis}, {31'd0, e.mis});
`endif
    endtask

    // Drive one cycle of inputs, queue the expectation, then compare after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        stall                   = {5'($urandom), v.stall0};
        flush                   = v.flush;
        new_pc                  = v.new_pc;
        branch_flag_i           = v.br;
        branch_target_address_i = v.tgt;
        e = '{tag: v.tag, pc: v.exp_pc, ce: v.exp_ce, pend: v.exp_pend, mis: v.exp_mis};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", v.tag);
        end else begin
            check_outputs(sb.pop_front());
        end
    endtask

    function automatic vec_t mk(input string tag, input logic s0, input logic fl,
                                input logic [31:0] npc, input logic br, input logic [31:0] tgt,
                                input logic [31:0] epc, input logic ece, input logic epend,
                                input logic emis);
        vec_t v;
        v = '{tag: tag, stall0: s0, flush: fl, new_pc: npc, br: br, tgt: tgt,
              exp_pc: epc, exp_ce: ece, exp_pend: epend, exp_mis: emis};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;

        //            tag        stl fl  new_pc        br  target        exp_pc        ce  pnd mis
        vecs.push_back(mk("idle",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk("seq4",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 0, 0));
        vecs.push_back(mk("seq8",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 0, 0));
        vecs.push_back(mk("seqC",  0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 0, 0));
        vecs.push_back(mk("br100", 0, 0, 32'h0,        1, 32'h100,      32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk("s104",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 0, 0));
        vecs.push_back(mk("stb1",  1, 0, 32'h0,        1, 32'h200,      32'h0000_0104, 1, 1, 0));
        vecs.push_back(mk("stb2",  1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 1, 0));
        vecs.push_back(mk("stb3",  1, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 1, 0));
        vecs.push_back(mk("rel",   0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 0));
        vecs.push_back(mk("s204",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 1, 0, 0));
        vecs.push_back(mk("nw1",   1, 0, 32'h0,        1, 32'h300,      32'h0000_0204, 1, 1, 0));
        vecs.push_back(mk("nw2",   1, 0, 32'h0,        1, 32'h340,      32'h0000_0204, 1, 1, 0));
        vecs.push_back(mk("nwrel", 0, 0, 32'h0,        0, 32'h0,        32'h0000_0340, 1, 0, 0));
        vecs.push_back(mk("hold",  1, 0, 32'h0,        1, 32'h200,      32'h0000_0340, 1, 1, 0));
        vecs.push_back(mk("hflsh", 1, 1, 32'h20,       0, 32'h0,        32'h0000_0020, 1, 0, 0));
        vecs.push_back(mk("s24",   0, 0, 32'h0,        0, 32'h0,        32'h0000_0024, 1, 0, 0));
        vecs.push_back(mk("hold2", 1, 0, 32'h0,        1, 32'h500,      32'h0000_0024, 1, 1, 0));
        vecs.push_back(mk("cobr",  0, 0, 32'h0,        1, 32'h600,      32'h0000_0600, 1, 0, 0));
        vecs.push_back(mk("rflsh", 1, 1, 32'h40,       1, 32'h700,      32'h0000_0040, 1, 0, 0));
        vecs.push_back(mk("stl",   1, 0, 32'h0,        0, 32'h0,        32'h0000_0040, 1, 0, 0));
        vecs.push_back(mk("top",   0, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk("wrap",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk("wrp4",  0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 0, 0));

        rst                     = 1'b0;
        stall                   = '0;
        flush                   = 1'b0;
        new_pc                  = '0;
        branch_flag_i           = 1'b0;
        branch_target_address_i = '0;

        #1;
        e = '{tag: "rst0", pc: 32'h0, ce: 1'b0, pend: 1'b0, mis: 1'b0};
        check_outputs(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = '{tag: "rstrel", pc: 32'h0, ce: 1'b0, pend: 1'b0, mis: 1'b0};
        check_outputs(e);

        foreach (vecs[i]) step(vecs[i]);

`ifdef FETCH_ALIGN_CHECK_EN
        step(mk("mbr",   0, 0, 32'h0,  1, 32'h102, 32'h0000_0102, 0, 0, 1));
        step(mk("mfl",   0, 1, 32'h20, 0, 32'h0,   32'h0000_0020, 1, 0, 0));
`else
        step(mk("ubr",   0, 0, 32'h0,  1, 32'h102, 32'h0000_0102, 1, 0, 0));
        step(mk("ufl",   0, 1, 32'h20, 0, 32'h0,   32'h0000_0020, 1, 0, 0));
`endif

        // Reset asserted mid-stall with a redirect pending must act without a clock edge.
        step(mk("prerst", 1, 0, 32'h0, 1, 32'h800, 32'h0000_0020, 1, 1, 0));
        #3;
        rst = 1'b0;
        #1;
        e = '{tag: "arst", pc: 32'h0, ce: 1'b0, pend: 1'b0, mis: 1'b0};
        check_outputs(e);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = '{tag: "arel", pc: 32'h0, ce: 1'b0, pend: 1'b0, mis: 1'b0};
        check_outputs(e);
        step(mk("ridle", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0000, 1, 0, 0));
        step(mk("r4",    0, 0, 32'h0, 0, 32'h0, 32'h0000_0004, 1, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
